// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bundle between the fetch stage and imem.
// A word transfers on any cycle where imem_req and imem_ready are both 1; the
// requester holds imem_addr stable from the first cycle of imem_req until that cycle.
interface fetch_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// Fetch stage: PC, imem handshake FSM (FETCH/WAIT/HOLD), 1-entry stall buffer, IF/ID register.
// Define FETCH_ALIGN_CHECK_EN to add the sticky fetch_misalign flag for misaligned redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          flush,
    input  logic          branch_taken,
    input  logic [31:0]   branch_target,
    input  logic          jump_flag,
    input  logic [31:0]   jump_target,
    fetch_stage_if.master imem,
    output logic [31:0]   if_id_instr,
    output logic [31:0]   if_id_pc4,
    output logic          if_id_valid,
    output logic [5:0]    opcode,
    output logic [5:0]    funct,
    output logic [1:0]    o_dbg_state
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic          fetch_misalign
`endif
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_buf;
    logic        r_pend_valid;
    logic [31:0] r_pend_target;
    logic [31:0] r_if_instr;
    logic [31:0] r_if_pc4;
    logic        r_if_valid;

    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_halt;
    logic        w_req;
    logic        w_done;
    logic [31:0] w_pc4;

    assign w_redirect = branch_taken | jump_flag;
    assign w_target   = branch_taken ? branch_target : jump_target;
    assign w_req      = rst && !w_halt && (r_state != S_HOLD);
    assign w_done     = w_req && imem.imem_ready;
    assign w_pc4      = r_pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;

    // Once set, requests stop until reset so the bad address is never issued.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_misalign <= 1'b0;
        else if (w_redirect && (w_target[1:0] != 2'b00))
            r_misalign <= 1'b1;
    end

    assign w_halt         = r_misalign;
    assign fetch_misalign = r_misalign;
`else
    assign w_halt = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= S_FETCH;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        if (w_redirect) begin
            w_next_state = (w_req && !imem.imem_ready) ? S_WAIT : S_FETCH;
        end else begin
            case (r_state)
                S_FETCH, S_WAIT: begin
                    if (w_done)
                        w_next_state = (stall && !r_pend_valid) ? S_HOLD : S_FETCH;
                    else if (w_req)
                        w_next_state = S_WAIT;
                end
                S_HOLD: begin
                    if (!stall)
                        w_next_state = S_FETCH;
                end
                default: w_next_state = S_FETCH;
            endcase
        end
    end

    always_comb begin
        imem.imem_req  = w_req;
        imem.imem_addr = r_pc;
        o_dbg_state    = r_state;
    end

    // An in-flight request keeps its address, so a redirect arriving then is parked as pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_buf         <= 32'h0;
            r_pend_valid  <= 1'b0;
            r_pend_target <= 32'h0;
            r_if_instr    <= 32'h0;
            r_if_pc4      <= 32'h0;
            r_if_valid    <= 1'b0;
        end else if (w_redirect) begin
            r_if_valid <= 1'b0;
            r_if_instr <= 32'h0;
            if (w_req && !imem.imem_ready) begin
                r_pend_valid  <= 1'b1;
                r_pend_target <= w_target;
            end else begin
                r_pc         <= w_target;
                r_pend_valid <= 1'b0;
            end
        end else begin
            case (r_state)
                S_FETCH, S_WAIT: begin
                    if (w_done) begin
                        if (r_pend_valid) begin
                            r_pc         <= r_pend_target;
                            r_pend_valid <= 1'b0;
                        end else if (stall) begin
                            r_buf <= imem.imem_rdata;
                        end else begin
                            r_pc       <= w_pc4;
                            r_if_instr <= imem.imem_rdata;
                            r_if_pc4   <= w_pc4;
                            r_if_valid <= 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        r_pc       <= w_pc4;
                        r_if_instr <= r_buf;
                        r_if_pc4   <= w_pc4;
                        r_if_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Flush squashes IF/ID only; the PC and FSM keep advancing.
            if (flush) begin
                r_if_valid <= 1'b0;
                r_if_instr <= 32'h0;
            end
        end
    end

    assign if_id_instr = r_if_instr;
    assign if_id_pc4   = r_if_pc4;
    assign if_id_valid = r_if_valid;
    assign opcode      = r_if_instr[31:26];
    assign funct       = r_if_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Directed + short random bench for fetch_stage; IF/ID loads are checked against a fetched-address queue.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        jump_flag = 1'b0;
    logic [31:0] jump_target = 32'h0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [1:0]  dbg_state;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        misalign;
`endif

    fetch_stage_if imem_bus ();

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump_flag    (jump_flag),
        .jump_target  (jump_target),
        .imem         (imem_bus.master),
        .if_id_instr  (if_id_instr),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .opcode       (opcode),
        .funct        (funct),
        .o_dbg_state  (dbg_state)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_misalign(misalign)
`endif
    );

    // clock / reset
    always #5 clk = ~clk;

    // memory image: every word is a fixed scramble of its own address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1400_0003;
    endfunction

    assign imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);

    localparam logic [1:0] ST_FETCH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    // scoreboard
    logic [31:0] exp_q[$];
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] a);
        exp_q.push_back(a);
    endtask

    task automatic chk_load(input string tag);
        logic [31:0] a;
        logic [31:0] w;
        if (exp_q.size() == 0) a = 32'hDEAD_BEEC;
        else a = exp_q.pop_front();
        w = mem_word(a);
        chk({tag, "_valid"}, {31'b0, if_id_valid}, 32'd1);
        chk({tag, "_instr"}, if_id_instr, w);
        chk({tag, "_pc4"}, if_id_pc4, a + 32'd4);
        chk({tag, "_opcode"}, {26'b0, opcode}, {26'b0, w[31:26]});
        chk({tag, "_funct"}, {26'b0, funct}, {26'b0, w[5:0]});
    endtask

    task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
        chk({tag, "_req"}, {31'b0, imem_bus.imem_req}, {31'b0, req});
        chk({tag, "_addr"}, imem_bus.imem_addr, addr);
    endtask

    task automatic chk_squashed(input string tag);
        chk({tag, "_valid0"}, {31'b0, if_id_valid}, 32'd0);
        chk({tag, "_instr0"}, if_id_instr, 32'h0);
    endtask

    logic [31:0] m_pc;
    logic        r_rdy;

    initial begin
        imem_bus.imem_ready = 1'b1;
        // reset state
        tick();
        tick();
        chk("rst_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("rst_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
        chk("rst_pc4", if_id_pc4, 32'h0);
        chk_squashed("rst");

        // sequential fetch after reset release
        rst = 1'b1;
        #1;
        chk_req("seq0", 1'b1, 32'h0);
        push_fetch(32'h0); tick(); chk_load("seq0");
        chk_req("seq1", 1'b1, 32'h4);
        push_fetch(32'h4); tick(); chk_load("seq1");
        chk_req("seq2", 1'b1, 32'h8);
        push_fetch(32'h8); tick(); chk_load("seq2");

        // imem_ready low for 3 cycles: address held, single load
        imem_bus.imem_ready = 1'b0;
        chk_req("wait0", 1'b1, 32'hC);
        tick();
        chk("wait_state", {30'b0, dbg_state}, {30'b0, ST_WAIT});
        chk("wait_noload", if_id_pc4, 32'hC);
        chk_req("wait1", 1'b1, 32'hC);
        tick(); chk_req("wait2", 1'b1, 32'hC);
        tick(); chk_req("wait3", 1'b1, 32'hC);
        imem_bus.imem_ready = 1'b1;
        push_fetch(32'hC); tick(); chk_load("wait_done");
        chk_req("wait_next", 1'b1, 32'h10);

        // stall at completion -> HOLD, then load buffered word
        stall = 1'b1;
        tick();
        chk("hold_state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
        chk("hold_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("hold_pc4", if_id_pc4, 32'h10);
        tick();
        chk("hold2_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("hold2_pc4", if_id_pc4, 32'h10);
        stall = 1'b0;
        push_fetch(32'h10); tick(); chk_load("hold_rel");
        chk_req("hold_next", 1'b1, 32'h14);

        // flush together with stall
        stall = 1'b1;
        flush = 1'b1;
        tick();
        chk_squashed("flush");
        chk("flush_pc", imem_bus.imem_addr, 32'h14);
        chk("flush_state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
        stall = 1'b0;
        flush = 1'b0;
        push_fetch(32'h14); tick(); chk_load("flush_rel");

        // branch + jump during WAIT: branch wins, in-flight word dropped
        imem_bus.imem_ready = 1'b0;
        tick();
        branch_taken  = 1'b1; branch_target = 32'h40;
        jump_flag     = 1'b1; jump_target   = 32'h80;
        tick();
        branch_taken = 1'b0;
        jump_flag    = 1'b0;
        chk_squashed("redir_wait");
        chk_req("redir_hold_addr", 1'b1, 32'h18);
        tick();
        chk_req("redir_hold_addr2", 1'b1, 32'h18);
        imem_bus.imem_ready = 1'b1;
        tick();
        chk("redir_drop", {31'b0, if_id_valid}, 32'd0);
        chk("redir_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
        chk_req("redir_target", 1'b1, 32'h40);
        push_fetch(32'h40); tick(); chk_load("redir_load");

        // jump alone in FETCH, then branch overriding a HOLD
        jump_flag = 1'b1; jump_target = 32'h100;
        tick();
        jump_flag = 1'b0;
        chk_squashed("jump");
        chk_req("jump_target", 1'b1, 32'h100);
        stall = 1'b1;
        tick();
        chk("jhold_state", {30'b0, dbg_state}, {30'b0, ST_HOLD});
        branch_taken = 1'b1; branch_target = 32'h200;
        tick();
        branch_taken = 1'b0;
        stall = 1'b0;
        chk("bhold_state", {30'b0, dbg_state}, {30'b0, ST_FETCH});
        chk_squashed("bhold");
        chk_req("bhold_target", 1'b1, 32'h200);
        push_fetch(32'h200); tick(); chk_load("bhold_load");

        // PC wrap at top of address space
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
        tick();
        branch_taken = 1'b0;
        chk_req("wrap_top", 1'b1, 32'hFFFF_FFFC);
        push_fetch(32'hFFFF_FFFC); tick(); chk_load("wrap_load");
        chk_req("wrap_zero", 1'b1, 32'h0);
        push_fetch(32'h0); tick(); chk_load("wrap_next");

        // random imem_ready backpressure against a PC model
        m_pc = 32'h4;
        for (int i = 0; i < 24; i++) begin
            r_rdy = 1'($urandom_range(0, 1));
            imem_bus.imem_ready = r_rdy;
            chk("rnd_addr", imem_bus.imem_addr, m_pc);
            if (r_rdy) push_fetch(m_pc);
            tick();
            if (r_rdy) begin
                chk_load("rnd_load");
                m_pc = m_pc + 32'd4;
            end
        end

        // reset in the middle of WAIT
        imem_bus.imem_ready = 1'b0;
        tick();
        chk("rwait_state", {30'b0, dbg_state}, {30'b0, ST_WAIT});
        rst = 1'b0;
        #1;
        chk("rwait_req", {31'b0, imem_bus.imem_req}, 32'd0);
        chk("rwait_pc", imem_bus.imem_addr, 32'h0);
        chk("rwait_state0", {30'b0, dbg_state}, {30'b0, ST_FETCH});
        chk("rwait_pc4", if_id_pc4, 32'h0);
        chk_squashed("rwait");
        tick();
        rst = 1'b1;
        imem_bus.imem_ready = 1'b1;
        #1;
        chk_req("rwait_first", 1'b1, 32'h0);
        push_fetch(32'h0); tick(); chk_load("rwait_load");

        chk("queue_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports stall  input  1 (hold PC and IF/ID) and flush  input  1 (squash IF/ID content).
REQ-005 SHALL have ports branch_taken  input  1 and branch_target  input  32 (branch redirect).
REQ-006 SHALL have ports jump_flag  input  1 and jump_target  input  32 (jump redirect).
REQ-007 SHALL have ports imem_req  output  1, imem_addr  output  32, imem_ready  input  1 and imem_rdata  input  32 (instruction memory handshake).
REQ-008 SHALL have ports if_id_instr  output  32, if_id_pc4  output  32 and if_id_valid  output  1 (IF/ID register).
REQ-009 SHALL have ports opcode  output  6 (if_id_instr[31:26]) and funct  output  6 (if_id_instr[5:0]), both fed to the decode/control stage.

Function
REQ-010 SHALL implement FSM states FETCH, WAIT and HOLD, with FETCH entered on reset.
REQ-011 FETCH/WAIT SHALL drive imem_req=1 and imem_addr=pc; the address SHALL be stable until imem_ready=1.
REQ-012 A transfer SHALL complete on a cycle with imem_req=1 and imem_ready=1; completion in the same cycle is allowed, giving 1-cycle latency.
REQ-013 Completion with stall=0 and no redirect SHALL load if_id_instr=imem_rdata, if_id_pc4=pc+4 and if_id_valid=1, set pc<=pc+4 (mod 2^32, wrap 32'hFFFF_FFFC->0) and stay in FETCH.
REQ-014 Completion with stall=1 SHALL hold the returned word in a 1-entry buffer, go to HOLD with imem_req=0, and leave pc and IF/ID unchanged.
REQ-015 HOLD SHALL, on the first cycle with stall=0, load the buffered word into IF/ID, advance pc by 4 and return to FETCH.
REQ-016 imem_ready=0 in FETCH SHALL move the FSM to WAIT; the request SHALL persist until imem_ready=1.
REQ-017 Redirect priority SHALL be branch_taken > jump_flag > sequential; the redirect target SHALL be the next pc.
REQ-018 A redirect SHALL force if_id_valid=0 and if_id_instr=32'h0 next cycle, overriding stall.
REQ-019 A redirect SHALL discard any HOLD buffer, with the FSM returning to FETCH.
REQ-020 A redirect during WAIT SHALL latch the target in a pending register; the in-flight word SHALL be discarded on completion, and the next request SHALL use the pending target.
REQ-021 flush=1 SHALL clear IF/ID (valid=0, instr=0) regardless of stall; pc and FSM SHALL be unaffected unless a redirect is also active.
REQ-022 stall=1 without flush/redirect SHALL hold pc, if_id_* and any pending target unchanged.
REQ-023 opcode and funct SHALL be purely combinational slices of if_id_instr.

Reset
REQ-024 Asserting rst low SHALL immediately set pc=RESET_PC, FSM=FETCH, if_id_instr=0, if_id_pc4=0, if_id_valid=0, buffer/pending cleared.
REQ-025 A reset during WAIT SHALL abandon the transfer; after release the first request SHALL be to RESET_PC.
REQ-026 imem_req SHALL be 0 while rst is low.

Configuration
REQ-027 With macro FETCH_ALIGN_CHECK_EN defined, the block SHALL add output fetch_misalign (1 bit), set with if_id_valid=0 when a redirect target has [1:0]!=0.
REQ-028 With FETCH_ALIGN_CHECK_EN defined, fetch_misalign SHALL be sticky until reset, and no request SHALL be issued to the misaligned address.
REQ-029 Without FETCH_ALIGN_CHECK_EN, the port SHALL be absent and targets SHALL be used as given.

Verification
REQ-030 Reset release, imem_ready tied 1, rdata=addr -> requests 0,4,8; if_id_valid=1 from cycle 2, if_id_pc4=4,8,12.
REQ-031 imem_ready low 3 cycles at addr 8 -> imem_addr stays 8 four cycles; one IF/ID load only.
REQ-032 stall=1 for 2 cycles at completion of addr 4 -> HOLD, imem_req=0; IF/ID loads word 4 when stall drops; next request 8.
REQ-033 branch_taken=1 target 0x40 with jump_flag=1 target 0x80 during WAIT -> in-flight word dropped, if_id_valid=0, next request 0x40.
REQ-034 flush=1 with stall=1 -> if_id_valid=0, pc unchanged; rst low mid-WAIT -> all outputs reset, first request RESET_PC.
